// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the iterative divide unit: operation codes, FSM states, default width.
package div_sequencer_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef logic [1:0] op_t;
  localparam op_t OP_DIV  = 2'b00;
  localparam op_t OP_DIVU = 2'b01;
  localparam op_t OP_REM  = 2'b10;
  localparam op_t OP_REMU = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ABS_A = 3'd1;
  localparam state_t S_ABS_B = 3'd2;
  localparam state_t S_DIV   = 3'd3;
  localparam state_t S_NEG_Q = 3'd4;
  localparam state_t S_NEG_R = 3'd5;
  localparam state_t S_DONE  = 3'd6;

endpackage

// File: rtl/div_sequencer_cla_adder.sv
// Carry-lookahead adder/subtractor: sum = a + (sub ? ~b : b) + sub, built from 4-bit lookahead groups.
module cla_adder #(
  parameter int InputSize = 64
) (
  input  logic [InputSize-1:0] a,
  input  logic [InputSize-1:0] b,
  input  logic                 sub,
  output logic [InputSize-1:0] sum,
  output logic                 c_o
);

  logic [InputSize-1:0] bx, g, p;
  logic [3:0] gg, pp, cc;
  logic       carry;

  assign bx = b ^ {InputSize{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Carries inside each group come straight from the group carry-in; only group carries chain.
  always_comb begin
    sum   = '0;
    gg    = '0;
    pp    = '0;
    cc    = '0;
    carry = sub;
    for (int blk = 0; blk < InputSize / 4; blk++) begin
      gg    = g[blk*4 +: 4];
      pp    = p[blk*4 +: 4];
      cc[0] = carry;
      cc[1] = gg[0] | (pp[0] & carry);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & carry);
      sum[blk*4 +: 4] = pp ^ cc;
      carry = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
              (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & carry);
    end
    c_o = carry;
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative RV64M DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle,
// with operand/result negation done on the same shared subtracting adder.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t          state;
  logic [1:0]      op_r;
  logic [XLEN-1:0] q, rem, dvsr, result_reg, final_val;
  logic [CW-1:0]   count;
  logic            sign_q, sign_r;

  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_co;
  logic            sh;
  logic [XLEN-1:0] rem_sh;
  logic            div_zero, overflow, take;

  assign {sh, rem_sh} = {rem, q[XLEN-1]};
  assign take         = sh | add_co;

  assign div_zero = (divisor == '0);
  assign overflow = ~op[0] && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  cla_adder #(.InputSize(XLEN)) u_adder (
    .a  (add_a),
    .b  (add_b),
    .sub(1'b1),
    .sum(add_sum),
    .c_o(add_co)
  );

  // Every state but DIV uses the adder as a negator (0 - x).
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      S_ABS_A: add_b = q;
      S_ABS_B: add_b = dvsr;
      S_DIV: begin
        add_a = rem_sh;
        add_b = dvsr;
      end
      S_NEG_Q: add_b = q;
      S_NEG_R: add_b = rem;
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) && !kill;
  assign final_val = op_r[1] ? rem : q;
  assign result    = done ? final_val : result_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_r       <= '0;
      q          <= '0;
      rem        <= '0;
      dvsr       <= '0;
      result_reg <= '0;
      count      <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
    end else if (kill && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_r   <= op;
            dvsr   <= divisor;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            count  <= CW'(XLEN - 1);
            if (div_zero) begin
              q     <= '1;
              rem   <= dividend;
              state <= S_DONE;
            end else if (overflow) begin
              q     <= dividend;
              rem   <= '0;
              state <= S_DONE;
            end else begin
              q     <= dividend;
              rem   <= '0;
              state <= op[0] ? S_DIV : S_ABS_A;
            end
          end
        end
        S_ABS_A: begin
          sign_r <= q[XLEN-1];
          if (q[XLEN-1]) q <= add_sum;
          state <= S_ABS_B;
        end
        S_ABS_B: begin
          sign_q <= sign_r ^ dvsr[XLEN-1];
          if (dvsr[XLEN-1]) dvsr <= add_sum;
          count <= CW'(XLEN - 1);
          state <= S_DIV;
        end
        S_DIV: begin
          q   <= {q[XLEN-2:0], take};
          rem <= take ? add_sum : rem_sh;
          if (count == '0) state <= op_r[0] ? S_DONE : S_NEG_Q;
          else             count <= count - 1'b1;
        end
        S_NEG_Q: begin
          if (sign_q) q <= add_sum;
          state <= S_NEG_R;
        end
        S_NEG_R: begin
          if (sign_r) rem <= add_sum;
          state <= S_DONE;
        end
        S_DONE: begin
          result_reg <= final_val;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (XLEN=64): hand-computed results and start-to-done latencies.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] dividend, divisor;
  logic        kill;
  logic        busy, done;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  div_sequencer #(.XLEN(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from accept to done, check result and busy framing.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, " busy_after_accept"}, {63'd0, busy}, 64'd1);
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
    check({tag, " held"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; kill = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, result[61:0]}, 64'd0);
    check("reset_result", result, 64'd0);
    reset = 1'b0;

    run_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    run_op("rem_m7_2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 69);
    run_op("div_m7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 69);
    run_op("div_7_m2", OP_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 69);
    run_op("rem_7_m2", OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 69);
    run_op("div_5_0", OP_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_5_0", OP_REMU, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("div_min_3", OP_DIV, 64'h8000_0000_0000_0000, 64'd3, 64'hD555_5555_5555_5556, 69);
    run_op("rem_min_3", OP_REM, 64'h8000_0000_0000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 69);
    run_op("divu_big", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65);
    run_op("remu_big", OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
           64'h7FFF_FFFF_FFFF_FFFE, 65);

    // Ignored second start, then kill mid-division.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 64'd1000; divisor = 64'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = OP_DIV; dividend = 64'd5; divisor = 64'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored", {62'd0, busy, done}, 64'd2);
    repeat (8) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("kill_no_done", 64'(dones), 64'd0);
    check("kill_result_kept", result, 64'h7FFF_FFFF_FFFF_FFFE);

    // start coinciding with kill in IDLE is dropped.
    start = 1'b1; kill = 1'b1; op = OP_DIVU; dividend = 64'd9; divisor = 64'd3;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("idle_kill_drops_start", {63'd0, busy}, 64'd0);

    run_op("divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 65);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 64'd100; divisor = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctrl", {62'd0, busy, done}, 64'd0);
    check("async_reset_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("rem_m7_2_after_reset", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
